// File: rtl/stage_sequencer.sv
// stage_sequencer: one-hot enable/done sequencer for NSTAGE worker stages
// with per-frame skipping, frame pacing, stage watchdog, pause and frame count.
module stage_sequencer #(
    parameter int NSTAGE  = 3,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000,
    parameter int FRAME_W = 8,
    localparam int SW     = $clog2(NSTAGE)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               ena_i,
    input  logic               pause_i,
    input  logic [NSTAGE-1:0]  skip_i,
    input  logic [CNT_W-1:0]   frame_period_i,
    input  logic [NSTAGE-1:0]  done_i,
    output logic [NSTAGE-1:0]  en_o,
    output logic [SW-1:0]      stage_o,
    output logic [FRAME_W-1:0] frame_o,
    output logic               frame_tick_o,
    output logic               timeout_o,
    output logic [SW-1:0]      to_stage_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WAIT_FRAME
    } state_t;

    localparam logic [CNT_W-1:0] WD_LIM =
        CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    localparam logic [NSTAGE-1:0] ONE = NSTAGE'(1);

    state_t             state_q, state_d;
    logic [NSTAGE-1:0]  en_q, en_d;
    logic [SW-1:0]      stage_q, stage_d;
    logic [NSTAGE-1:0]  skip_q, skip_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   wd_q, wd_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               tick_q, tick_d;
    logic               to_q, to_d;
    logic [SW-1:0]      to_stage_q, to_stage_d;

    logic               first_ok;
    logic [SW-1:0]      first_idx;
    logic               next_ok;
    logic [SW-1:0]      next_idx;
    logic               done_k;
    logic               wd_exp;
    logic [CNT_W:0]     period_p1;
    logic               period_done;
    logic [CNT_W-1:0]   period_inc;
    logic [CNT_W-1:0]   wd_inc;
    logic               start;
    logic               complete;

    // lowest stage not skipped by the incoming skip mask
    always_comb begin
        first_ok  = 1'b0;
        first_idx = '0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            if (!skip_i[i]) begin
                first_ok  = 1'b1;
                first_idx = SW'(i);
            end
        end
    end

    always_comb begin
        next_ok  = 1'b0;
        next_idx = '0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            if (i > int'(stage_q) && !skip_q[i]) begin
                next_ok  = 1'b1;
                next_idx = SW'(i);
            end
        end
    end

    assign done_k = done_i[stage_q];
    assign wd_exp = (TIMEOUT > 0) && (wd_q == WD_LIM);

    // period_cnt+1 is the frame length so far, counting the current cycle
    assign period_p1   = {1'b0, period_q} + (CNT_W + 1)'(1);
    assign period_done = period_p1 >= {1'b0, frame_period_i};
    assign period_inc  = (&period_q) ? period_q : period_q + CNT_W'(1);
    assign wd_inc      = (&wd_q) ? wd_q : wd_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        stage_d    = stage_q;
        skip_d     = skip_q;
        period_d   = period_inc;
        wd_d       = wd_inc;
        frame_d    = frame_q;
        tick_d     = 1'b0;
        to_d       = to_q;
        to_stage_d = to_stage_q;
        start      = 1'b0;
        complete   = 1'b0;

        unique case (state_q)
            IDLE: begin
                period_d = period_q;
                if (ena_i && !pause_i)
                    start = 1'b1;
            end
            RUN: begin
                if (done_k || wd_exp) begin
                    if (!done_k) begin
                        to_d = 1'b1;
                        if (!to_q)
                            to_stage_d = stage_q;
                    end
                    wd_d = '0;
                    if (next_ok) begin
                        en_d    = ONE << next_idx;
                        stage_d = next_idx;
                    end else begin
                        complete = 1'b1;
                    end
                end
            end
            WAIT_FRAME: begin
                if (period_done) begin
                    if (ena_i && !pause_i)
                        start = 1'b1;
                    else if (!ena_i)
                        state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = '0;
            end
        endcase

        if (start) begin
            skip_d   = skip_i;
            period_d = '0;
            wd_d     = '0;
            if (first_ok) begin
                en_d    = ONE << first_idx;
                stage_d = first_idx;
                state_d = RUN;
            end else begin
                complete = 1'b1;
            end
        end

        if (complete) begin
            en_d    = '0;
            frame_d = frame_q + FRAME_W'(1);
            tick_d  = 1'b1;
            state_d = WAIT_FRAME;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            en_q       <= '0;
            stage_q    <= '0;
            skip_q     <= '0;
            period_q   <= '0;
            wd_q       <= '0;
            frame_q    <= '0;
            tick_q     <= 1'b0;
            to_q       <= 1'b0;
            to_stage_q <= '0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            stage_q    <= stage_d;
            skip_q     <= skip_d;
            period_q   <= period_d;
            wd_q       <= wd_d;
            frame_q    <= frame_d;
            tick_q     <= tick_d;
            to_q       <= to_d;
            to_stage_q <= to_stage_d;
        end
    end

    assign en_o         = en_q;
    assign stage_o      = stage_q;
    assign frame_o      = frame_q;
    assign frame_tick_o = tick_q;
    assign timeout_o    = to_q;
    assign to_stage_o   = to_stage_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed bench for stage_sequencer with
// NSTAGE=3, TIMEOUT=8 and behavioural stage responders.
module tb_stage_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       ena_i = 1'b0;
    logic       pause_i = 1'b0;
    logic [2:0] skip_i = '0;
    logic [15:0] frame_period_i = '0;
    logic [2:0] done_i = '0;
    logic [2:0] en_o;
    logic [1:0] stage_o;
    logic [7:0] frame_o;
    logic       frame_tick_o;
    logic       timeout_o;
    logic [1:0] to_stage_o;

    stage_sequencer #(
        .NSTAGE(3),
        .CNT_W(16),
        .TIMEOUT(8),
        .FRAME_W(8)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .ena_i(ena_i),
        .pause_i(pause_i),
        .skip_i(skip_i),
        .frame_period_i(frame_period_i),
        .done_i(done_i),
        .en_o(en_o),
        .stage_o(stage_o),
        .frame_o(frame_o),
        .frame_tick_o(frame_tick_o),
        .timeout_o(timeout_o),
        .to_stage_o(to_stage_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_err = 0;
    int lat [3] = '{2, 2, 2};
    int cnt [3] = '{0, 0, 0};

    logic [2:0] exp_en [64];
    logic       exp_tk [64];
    int         exp_n = 0;

    // each stage raises done for one cycle after lat+1 cycles of enable;
    // lat < 0 means the stage never answers
    initial begin
        forever begin
            @(negedge clk_i);
            for (int k = 0; k < 3; k++) begin
                if (en_o[k]) cnt[k]++;
                else cnt[k] = 0;
                done_i[k] = en_o[k] && lat[k] >= 0 && cnt[k] == lat[k] + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    function automatic logic [31:0] oh_idx(input logic [2:0] v);
        if (v == 3'b100) return 2;
        if (v == 3'b010) return 1;
        return 0;
    endfunction

    task automatic push(input logic [2:0] v, input int c, input logic tk);
        for (int i = 0; i < c; i++) begin
            exp_en[exp_n] = v;
            exp_tk[exp_n] = tk && (i == c - 1);
            exp_n++;
        end
    endtask

    task automatic run_exp(input string tag);
        for (int i = 0; i < exp_n; i++) begin
            step();
            chk({tag, "_en"}, en_o, exp_en[i]);
            chk({tag, "_tick"}, frame_tick_o, exp_tk[i]);
            if (exp_en[i] != 3'b000)
                chk({tag, "_stage"}, stage_o, oh_idx(exp_en[i]));
        end
        exp_n = 0;
    endtask

    task automatic wait_tick(input string tag, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_tick_o && n < 200);
        chk(tag, frame_tick_o, 1);
    endtask

    initial begin
        int n;

        // reset state
        step();
        chk("rst_en", en_o, 0);
        chk("rst_stage", stage_o, 0);
        chk("rst_frame", frame_o, 0);
        chk("rst_tick", frame_tick_o, 0);
        chk("rst_to", timeout_o, 0);
        chk("rst_tostage", to_stage_o, 0);
        step();
        chk("idle_en", en_o, 0);
        rst_i = 1'b0;
        ena_i = 1'b1;

        // basic three-stage sequence, free-running
        push(3'b001, 3, 0);
        push(3'b010, 3, 0);
        push(3'b100, 3, 0);
        push(3'b000, 1, 1);
        run_exp("t1");
        chk("t1_frame", frame_o, 1);
        step();
        chk("t1_restart", en_o, 3'b001);

        // frame pacing: 20-cycle frames
        frame_period_i = 16'd20;
        wait_tick("t2_tick2", n);
        n = 0;
        while (en_o == 3'b000 && n < 100) begin
            n++;
            step();
        end
        chk("t2_idle_cycles", n, 11);
        wait_tick("t2_tick3", n);
        wait_tick("t2_tick4", n);
        chk("t2_gap", n, 20);
        chk("t2_frame", frame_o, 4);

        // skip the middle stage
        frame_period_i = 16'd0;
        skip_i = 3'b010;
        push(3'b001, 3, 0);
        push(3'b100, 3, 0);
        push(3'b000, 1, 1);
        run_exp("t3");
        chk("t3_frame", frame_o, 5);

        // all stages skipped: tick every cycle
        skip_i = 3'b111;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_tick", frame_tick_o, 1);
            chk("t4_en", en_o, 0);
            chk("t4_frame", frame_o, 6 + i);
        end

        // all skipped with period 4
        frame_period_i = 16'd4;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t5_tick", frame_tick_o, (i == 3 || i == 7) ? 1 : 0);
        end
        chk("t5_frame", frame_o, 10);
        chk("t5_to_clear", timeout_o, 0);

        // stage 1 never answers: watchdog after 8 cycles
        frame_period_i = 16'd0;
        skip_i = 3'b000;
        lat[1] = -1;
        push(3'b001, 3, 0);
        push(3'b010, 8, 0);
        push(3'b100, 3, 0);
        push(3'b000, 1, 1);
        run_exp("t6");
        chk("t6_to", timeout_o, 1);
        chk("t6_tostage", to_stage_o, 1);
        chk("t6_frame", frame_o, 11);

        // later stage 2 timeout keeps first index
        lat[1] = 2;
        lat[2] = -1;
        push(3'b001, 3, 0);
        push(3'b010, 3, 0);
        push(3'b100, 8, 0);
        push(3'b000, 1, 1);
        run_exp("t7");
        chk("t7_to", timeout_o, 1);
        chk("t7_tostage", to_stage_o, 1);
        chk("t7_frame", frame_o, 12);
        lat[2] = 2;

        // pause raised mid stage 1
        push(3'b001, 3, 0);
        push(3'b010, 2, 0);
        run_exp("t8a");
        pause_i = 1'b1;
        push(3'b010, 1, 0);
        push(3'b100, 3, 0);
        push(3'b000, 1, 1);
        push(3'b000, 5, 0);
        run_exp("t8b");
        chk("t8_frame", frame_o, 13);
        pause_i = 1'b0;
        step();
        chk("t8_restart", en_o, 3'b001);

        // ena dropped mid stage 0: frame finishes, then idle
        ena_i = 1'b0;
        push(3'b001, 2, 0);
        push(3'b010, 3, 0);
        push(3'b100, 3, 0);
        push(3'b000, 1, 1);
        push(3'b000, 4, 0);
        run_exp("t9");
        chk("t9_frame", frame_o, 14);
        ena_i = 1'b1;
        step();
        chk("t9_restart", en_o, 3'b001);

        // asynchronous reset while stage 1 is enabled
        n = 0;
        while (en_o != 3'b010 && n < 50) begin
            step();
            n++;
        end
        chk("t10_reach", en_o, 3'b010);
        #2 rst_i = 1'b1;
        #1;
        chk("t10_async_en", en_o, 0);
        chk("t10_async_frame", frame_o, 0);
        chk("t10_async_to", timeout_o, 0);
        chk("t10_async_tostage", to_stage_o, 0);
        step();
        chk("t10_hold_en", en_o, 0);
        rst_i = 1'b0;
        step();
        chk("t10_restart", en_o, 3'b001);
        chk("t10_stage", stage_o, 0);
        chk("t10_frame", frame_o, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
